// File: rtl/uart_tx_scheduler_if.sv
// ============================================================================
// uart_tx_scheduler_if : requester byte streams and serializer byte handshake
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  // master: report generators plus serializer; slave: the scheduler
  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_valid
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// uart_tx_scheduler : round-robin message arbiter in front of a UART byte TX.
// Optional stall timeout: define UART_SCHED_TIMEOUT_EN.   Rev 1.0 - initial
// ============================================================================
`default_nettype none

module uart_tx_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 13,
  parameter int TIMEOUT    = 1024
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_scheduler_if.slave bus,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               abort
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PW-1:0] C_PTR_RST  = PW'(NUM_REQ - 1);
  localparam logic [GW-1:0] C_GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [GW-1:0]      gap_q, gap_d;

  logic               w_pick_found;
  logic [PW-1:0]      w_pick_idx;
  logic               w_owner_valid;
  logic               w_owner_last;
  logic [7:0]         w_owner_data;
  logic               w_tx_valid;
  logic [7:0]         w_tx_data;
  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_msg_done;
  logic               w_timeout_hit;

  assign w_owner_valid = bus.req_valid[owner_q];
  assign w_owner_last  = bus.req_last[owner_q];
  assign w_owner_data  = bus.req_data[{owner_q, 3'b000} +: 8];

  // Rotating search starting one past the last finished owner.
  always_comb begin : p_arb
    int idx;
    idx          = 0;
    w_pick_found = 1'b0;
    w_pick_idx   = ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_pick_found && bus.req_valid[idx]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = PW'(idx);
      end
    end
  end

  // Pass-through is also blanked while rst is high so an abandoned
  // message cannot hand one more byte to the serializer.
  always_comb begin : p_datapath
    w_tx_valid  = 1'b0;
    w_tx_data   = 8'h00;
    w_req_ready = '0;
    if (state_q == ST_XFER && !rst) begin
      w_tx_valid  = w_owner_valid;
      w_tx_data   = w_owner_data;
      w_req_ready = grant_q & {NUM_REQ{bus.tx_ready}};
    end
    w_msg_done = w_tx_valid && bus.tx_ready && w_owner_last;
  end

  always_comb begin : p_next
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (w_pick_found) begin
          grant_d             = '0;
          grant_d[w_pick_idx] = 1'b1;
          owner_d             = w_pick_idx;
          state_d             = ST_XFER;
        end
      end
      ST_XFER: begin
        if (w_msg_done || w_timeout_hit) begin
          ptr_d   = owner_q;
          grant_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            gap_d   = C_GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= C_PTR_RST;
      owner_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gap_q   <= gap_d;
    end
  end

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] stall_q, stall_d;

  // Only cycles where the owner has nothing to offer count as a stall.
  always_comb begin : p_stall
    stall_d       = '0;
    w_timeout_hit = 1'b0;
    if (state_q == ST_XFER && !w_owner_valid && !rst) begin
      if (stall_q == TW'(TIMEOUT - 1)) w_timeout_hit = 1'b1;
      else                             stall_d       = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign abort = w_timeout_hit;
`else
  assign w_timeout_hit = 1'b0;
  assign abort         = 1'b0;
`endif

  assign bus.tx_valid  = w_tx_valid;
  assign bus.tx_data   = w_tx_data;
  assign bus.req_ready = w_req_ready;
  assign grant         = grant_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
// tb_uart_tx_scheduler : directed vector table plus multi-cycle sequences.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

  logic       clk;
  logic       rst;
  logic [1:0] grant;
  logic       busy;
  logic       abort;
  int         total;
  int         bad;

  uart_tx_scheduler_if #(.NUM_REQ(2)) bus ();

  uart_tx_scheduler #(
    .NUM_REQ   (2),
    .GAP_CYCLES(13),
    .TIMEOUT   (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .grant(grant),
    .busy (busy),
    .abort(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  rv;
    logic [15:0] rd;
    logic [1:0]  rl;
    logic        tr;
    logic        tv;
    logic [7:0]  td;
    logic [1:0]  rr;
    logic [1:0]  g;
    logic        b;
  } vec_t;

  vec_t vecs[22];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_last  = 2'b00;
    bus.tx_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drive at posedge+1, sample at posedge+2.
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rst           = vecs[i].rst;
      bus.req_valid = vecs[i].rv;
      bus.req_data  = vecs[i].rd;
      bus.req_last  = vecs[i].rl;
      bus.tx_ready  = vecs[i].tr;
      #1;
      check($sformatf("v%0d_tx_valid", i), 32'(bus.tx_valid), 32'(vecs[i].tv));
      check($sformatf("v%0d_tx_data", i), 32'(bus.tx_data), 32'(vecs[i].td));
      check($sformatf("v%0d_req_ready", i), 32'(bus.req_ready), 32'(vecs[i].rr));
      check($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].g));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].b));
      check($sformatf("v%0d_abort", i), 32'(abort), 32'd0);
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap_cnt;
    int grants_seen;
    int last_cyc;
    logic [1:0] prev_g;
    logic [1:0] exp_g[4];
    int cnt[2];
    logic hold_ok;

    total = 0;
    bad   = 0;
    bus.req_data = 16'h0000;

    //            rst   rv     rd        rl     tr    tv    td     rr     g      b
    // Reset with every requester valid, then "SM1928" from req 0 while req 1 waits.
    vecs[0]  = '{1'b1, 2'b11, 16'hEE53, 2'b10, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0};
    vecs[1]  = '{1'b0, 2'b11, 16'hEE53, 2'b10, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0};
    vecs[2]  = '{1'b0, 2'b11, 16'hEE53, 2'b10, 1'b1, 1'b1, 8'h53, 2'b01, 2'b01, 1'b1};
    vecs[3]  = '{1'b0, 2'b11, 16'hEE4D, 2'b10, 1'b1, 1'b1, 8'h4D, 2'b01, 2'b01, 1'b1};
    vecs[4]  = '{1'b0, 2'b11, 16'hEE31, 2'b10, 1'b1, 1'b1, 8'h31, 2'b01, 2'b01, 1'b1};
    vecs[5]  = '{1'b0, 2'b11, 16'hEE39, 2'b10, 1'b1, 1'b1, 8'h39, 2'b01, 2'b01, 1'b1};
    vecs[6]  = '{1'b0, 2'b11, 16'hEE32, 2'b10, 1'b1, 1'b1, 8'h32, 2'b01, 2'b01, 1'b1};
    vecs[7]  = '{1'b0, 2'b11, 16'hEE38, 2'b11, 1'b1, 1'b1, 8'h38, 2'b01, 2'b01, 1'b1};
    // tx_ready toggling during a 3-byte message.
    vecs[8]  = '{1'b0, 2'b01, 16'h00A1, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0};
    vecs[9]  = '{1'b0, 2'b01, 16'h00A1, 2'b00, 1'b0, 1'b1, 8'hA1, 2'b00, 2'b01, 1'b1};
    vecs[10] = '{1'b0, 2'b01, 16'h00A1, 2'b00, 1'b1, 1'b1, 8'hA1, 2'b01, 2'b01, 1'b1};
    vecs[11] = '{1'b0, 2'b01, 16'h00A2, 2'b00, 1'b0, 1'b1, 8'hA2, 2'b00, 2'b01, 1'b1};
    vecs[12] = '{1'b0, 2'b01, 16'h00A2, 2'b00, 1'b1, 1'b1, 8'hA2, 2'b01, 2'b01, 1'b1};
    vecs[13] = '{1'b0, 2'b01, 16'h00A3, 2'b01, 1'b0, 1'b1, 8'hA3, 2'b00, 2'b01, 1'b1};
    vecs[14] = '{1'b0, 2'b01, 16'h00A3, 2'b01, 1'b1, 1'b1, 8'hA3, 2'b01, 2'b01, 1'b1};
    vecs[15] = '{1'b0, 2'b00, 16'h0000, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 1'b1};
    // Reset after byte 2 of 5, then restart from byte 0.
    vecs[16] = '{1'b0, 2'b01, 16'h00B0, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0};
    vecs[17] = '{1'b0, 2'b01, 16'h00B0, 2'b00, 1'b1, 1'b1, 8'hB0, 2'b01, 2'b01, 1'b1};
    vecs[18] = '{1'b0, 2'b01, 16'h00B1, 2'b00, 1'b1, 1'b1, 8'hB1, 2'b01, 2'b01, 1'b1};
    vecs[19] = '{1'b1, 2'b01, 16'h00B2, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 2'b01, 1'b1};
    vecs[20] = '{1'b0, 2'b01, 16'h00B0, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0};
    vecs[21] = '{1'b0, 2'b01, 16'h00B0, 2'b00, 1'b1, 1'b1, 8'hB0, 2'b01, 2'b01, 1'b1};

    do_reset();
    rst = 1'b1;
    run_vecs(0, 7);

    // GAP after "SM1928": exactly 13 busy cycles, req 1 then wins.
    bus.req_valid = 2'b10;
    bus.req_last  = 2'b10;
    gap_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!busy) break;
      gap_cnt++;
      check("gap_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("gap_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    check("gap_len", 32'(gap_cnt), 32'd13);
    check("gap_idle_grant", 32'(grant), 32'd0);
    tick();
    #1;
    check("fair_grant", 32'(grant), 32'b10);
    check("fair_tx_data", 32'(bus.tx_data), 32'hEE);
    check("fair_req_ready", 32'(bus.req_ready), 32'b10);
    tick();
    bus.req_valid = 2'b00;
    #1;
    check("single_byte_gap", 32'(busy && grant == 2'b00), 32'd1);

    // Two requesters always valid, 2-byte messages: grants 0,1,0,1.
    do_reset();
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    cnt[0] = 0; cnt[1] = 0;
    grants_seen = 0;
    last_cyc    = -1;
    prev_g      = 2'b00;
    bus.tx_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && grants_seen < 4; cyc++) begin
      bus.req_valid = 2'b11;
      bus.req_data  = {8'h20 + 8'(cnt[1]), 8'h10 + 8'(cnt[0])};
      bus.req_last  = {cnt[1] == 1, cnt[0] == 1};
      #1;
      if (grant != 2'b00 && prev_g == 2'b00) begin
        check($sformatf("rr_grant%0d", grants_seen), 32'(grant), 32'(exp_g[grants_seen]));
        if (grants_seen > 0)
          check($sformatf("rr_spacing%0d", grants_seen), 32'(cyc - last_cyc), 32'd15);
        grants_seen++;
      end
      for (int i = 0; i < 2; i++) begin
        if (bus.req_ready[i] && bus.tx_valid) begin
          check($sformatf("rr_data_r%0d", i), 32'(bus.tx_data),
                32'((i == 0 ? 8'h10 : 8'h20) + 8'(cnt[i])));
          if (cnt[i] == 1) last_cyc = cyc;
          cnt[i] = 1 - cnt[i];
        end
      end
      prev_g = grant;
      tick();
    end
    check("rr_grant_count", 32'(grants_seen), 32'd4);

    do_reset();
    run_vecs(8, 15);

    do_reset();
    run_vecs(16, 21);

    // Owner stalls after its first byte.
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_data  = 16'h00C0;
    bus.req_last  = 2'b00;
    bus.tx_ready  = 1'b1;
    #1;
    check("stall_idle_grant", 32'(grant), 32'd0);
    tick();
    #1;
    check("stall_first_byte", 32'({bus.tx_valid, bus.req_ready}), 32'b101);
    tick();
    bus.req_valid = 2'b00;
`ifdef UART_SCHED_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      #1;
      check($sformatf("timeout_abort_k%0d", k), 32'(abort), 32'(k == 8));
      tick();
    end
    #1;
    check("timeout_gap_busy", 32'(busy), 32'd1);
    check("timeout_gap_grant", 32'(grant), 32'd0);
    check("timeout_abort_pulse", 32'(abort), 32'd0);
`else
    hold_ok = 1'b1;
    for (int k = 0; k < 120; k++) begin
      #1;
      if (grant != 2'b01 || abort || !busy) hold_ok = 1'b0;
      tick();
    end
    check("stall_hold", 32'(hold_ok), 32'd1);
    #1;
    check("stall_grant", 32'(grant), 32'b01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Message-level arbiter that shares the single UART byte transmitter between several on-board report sources (sensor frame, bot ID, status). Each requester streams a message of bytes with a last flag. The scheduler grants one requester at a time in round-robin order and holds the grant until that requester's last byte is accepted. It then enforces an idle gap on the line before the next grant. It sits between the report generators and the UART serializer's byte-level valid/ready input.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- GAP_CYCLES, 13, idle clk cycles inserted after each message (0 = no gap)
- TIMEOUT, 1024, stall limit in clk cycles (used only with the macro)

Ports:
- clk  input  1  system clock; single clock domain
- rst  input  1  reset, synchronous, active-high
- req_valid  input  NUM_REQ  requester i has a byte on its data slice
- req_data  input  8*NUM_REQ  requester i byte at [8i+7:8i]
- req_last  input  NUM_REQ  current byte is the final byte of the message
- req_ready  output  NUM_REQ  byte of requester i accepted this cycle
- tx_data  output  8  byte to serializer
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  serializer accepts byte
- grant  output  NUM_REQ  one-hot current owner; 0 when not in XFER
- busy  output  1  state != IDLE
- abort  output  1  one-cycle pulse when a message is cut by timeout (tied 0 without macro)

## Operation
- State machine: IDLE, XFER, GAP (registered state, grant, rr pointer, gap counter).
- IDLE: if any req_valid, register grant = first requester with req_valid set, searching from pointer+1 upward with wrap; go to XFER. Otherwise stay in IDLE.
- XFER (owner g): tx_valid = req_valid[g], tx_data = req_data slice g, req_ready[g] = tx_ready. All other req_ready bits are 0. This path is combinational pass-through.
- A byte is transferred when tx_valid && tx_ready. A transfer with req_last[g] set -> pointer = g, grant cleared. Go to GAP, or to IDLE if GAP_CYCLES == 0.
- GAP: counter loads GAP_CYCLES-1 on entry and decrements each cycle; at 0 go to IDLE. In GAP, tx_valid = 0 and req_ready = 0.
- Non-owners are never served mid-message, even if the owner has req_valid low.
- Fairness: after g finishes, g has the lowest priority in the next arbitration.
- Single-byte message (req_last on the first byte) is legal and completes XFER in one transfer.
- Requester contract: req_data and req_last must stay stable while req_valid is high and req_ready is low. The scheduler does not check this.

## Timing
- Reset values: state IDLE, grant 0, req_ready 0, tx_valid 0, tx_data 0, busy 0, abort 0. Pointer = NUM_REQ-1, so requester 0 wins the first arbitration. Gap counter 0.
- Reset asserted mid-message: abandon the message on the next clk edge. No further bytes are accepted, and the requester must restart its message.
- Arbitration latency: req_valid seen in IDLE at cycle N -> grant and tx_valid at cycle N+1. The earliest first-byte transfer is cycle N+1.
- Throughput in XFER: one byte per cycle when req_valid and tx_ready are both held high.
- Message-to-message: last transfer at cycle M -> GAP for cycles M+1..M+GAP_CYCLES -> IDLE at M+GAP_CYCLES+1 -> next grant at M+GAP_CYCLES+2.
- With GAP_CYCLES = 0: IDLE at M+1, next grant at M+2.
- Simultaneous requests in IDLE: rotating priority as above. Requests arriving during XFER or GAP wait; they are not lost.

## Configuration
- UART_SCHED_TIMEOUT_EN defined:
  - In XFER, a counter counts consecutive cycles with req_valid[g] = 0. Cycles with tx_valid high and tx_ready low do not count; the counter resets to 0 on any cycle with req_valid[g] high.
  - When the count reaches TIMEOUT: abort pulses high for one cycle, pointer = g, grant clears, state goes to GAP (or to IDLE if GAP_CYCLES == 0).
- Not defined: no counter; abort is constant 0. An owner may stall indefinitely and hold the line.

## Test plan
- Reset: assert rst 2 cycles with all req_valid high -> grant 0, tx_valid 0, busy 0, abort 0. First grant = 0001 one cycle after rst drops.
- Single requester, 6-byte message "SM1928" with tx_ready always high -> tx_data sequence 0x53,0x4D,0x31,0x39,0x32,0x38 on 6 consecutive cycles. Then busy stays high for exactly 13 GAP cycles.
- Req 0 and req 1 both valid continuously, 2-byte messages -> grants alternate 0,1,0,1. Each grant starts 15 cycles after the previous grant's last transfer.
- tx_ready toggling 1,0 during a 3-byte message -> each byte held stable until accepted. req_ready mirrors tx_ready. Exactly 3 bytes are transferred.
- Mid-message rst after byte 2 of 5 -> tx_valid 0 the next cycle. The remaining bytes are not transferred. A new message from byte 0 is granted normally.
- With UART_SCHED_TIMEOUT_EN and TIMEOUT=8: owner drops req_valid after byte 1 -> abort pulse on the 8th idle cycle, then GAP. Without the macro the grant is held for 100+ cycles.
